// File: rtl/startup_sequencer_pkg.sv
// ============================================================================
// Module      : startup_pkg
// Description : Shared types and constants for the configuration startup
//               sequencer: state encoding, counter width, and the legal range
//               of the per-stage cycle parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package startup_pkg;

    // Width of the per-stage down-counter.
    localparam int CNT_W = 8;

    // Legal range for every *_CYCLES parameter.
    localparam int CYCLES_MIN = 1;
    localparam int CYCLES_MAX = 255;

    // Sequencer stages in the order they are visited.
    typedef enum logic [1:0] {
        S_GSR = 2'd0,
        S_GWE = 2'd1,
        S_GTS = 2'd2,
        S_EOS = 2'd3
    } state_e;

    // Counter preload for a stage lasting 'cycles' enabled edges.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

    // True when a cycle count lies inside the supported range.
    function automatic bit cycles_legal(input int cycles);
        return (cycles >= CYCLES_MIN) && (cycles <= CYCLES_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/startup_sequencer_if.sv
// ============================================================================
// Module      : startup_sequencer_if
// Description : Control/status bundle of the startup sequencer. Inputs CE,
//               KEEP, REQ; outputs GSR, GWE, GTS, EOS, DONE. When the
//               STARTUP_STATE_EN macro is defined, STATE and CNT are also
//               carried so a testbench can observe the sequencer internals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface startup_sequencer_if;
    import startup_pkg::*;

    logic             CE;
    logic             KEEP;
    logic             REQ;
    logic             GSR;
    logic             GWE;
    logic             GTS;
    logic             EOS;
    logic             DONE;
`ifdef STARTUP_STATE_EN
    logic [1:0]       STATE;
    logic [CNT_W-1:0] CNT;
`endif

`ifdef STARTUP_STATE_EN
    // Environment side: drives the controls, observes the globals.
    modport master (
        output CE, KEEP, REQ,
        input  GSR, GWE, GTS, EOS, DONE, STATE, CNT
    );

    // Sequencer side.
    modport slave (
        input  CE, KEEP, REQ,
        output GSR, GWE, GTS, EOS, DONE, STATE, CNT
    );
`else
    // Environment side: drives the controls, observes the globals.
    modport master (
        output CE, KEEP, REQ,
        input  GSR, GWE, GTS, EOS, DONE
    );

    // Sequencer side.
    modport slave (
        input  CE, KEEP, REQ,
        output GSR, GWE, GTS, EOS, DONE
    );
`endif

endinterface

`default_nettype wire

// File: rtl/startup_sequencer.sv
// ============================================================================
// Module      : startup_sequencer
// Description : FPGA configuration startup sequencer. Produces the global
//               GSR / GWE / GTS controls and EOS / DONE after configurable
//               numbers of enabled clock edges. CLR is an asynchronous,
//               active-high restart. IS_C_INVERTED selects the falling edge
//               of C as the active edge.
//               Optional macro STARTUP_STATE_EN exposes STATE and CNT on the
//               interface for observation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module startup_sequencer
    import startup_pkg::*;
#(
    parameter bit IS_C_INVERTED = 1'b0,
    parameter int GSR_CYCLES    = 8,
    parameter int GTS_CYCLES    = 4,
    parameter int DONE_CYCLES   = 2
) (
    input  wire logic          C,
    input  wire logic          CLR,
    startup_sequencer_if.slave bus
);

    // Counter preloads on entry to each stage.
    localparam logic [CNT_W-1:0] c_gsr_load  = cnt_load(GSR_CYCLES);
    localparam logic [CNT_W-1:0] c_gts_load  = cnt_load(GTS_CYCLES);
    localparam logic [CNT_W-1:0] c_done_load = cnt_load(DONE_CYCLES);

    // Reject cycle counts that do not fit the 8-bit counter or are zero.
    if (!cycles_legal(GSR_CYCLES)) begin : g_bad_gsr_cycles
        $error("startup_sequencer: GSR_CYCLES out of range 1..255");
    end
    if (!cycles_legal(GTS_CYCLES)) begin : g_bad_gts_cycles
        $error("startup_sequencer: GTS_CYCLES out of range 1..255");
    end
    if (!cycles_legal(DONE_CYCLES)) begin : g_bad_done_cycles
        $error("startup_sequencer: DONE_CYCLES out of range 1..255");
    end

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next stage and counter: count down inside a stage, reload on advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.CE) begin
            case (state_q)
                S_GSR: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_GWE;
                        cnt_d   = c_gts_load;
                    end
                end
                S_GWE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_GTS;
                        cnt_d   = c_done_load;
                    end
                end
                S_GTS: begin
                    // KEEP only matters once the stage has run out; the
                    // counter then sits at zero until KEEP drops.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!bus.KEEP) begin
                        state_d = S_EOS;
                    end
                end
                S_EOS: begin
                    if (bus.REQ) begin
                        state_d = S_GSR;
                        cnt_d   = c_gsr_load;
                    end
                end
                default: begin
                    state_d = S_GSR;
                    cnt_d   = c_gsr_load;
                end
            endcase
        end
    end

    // One state register per clock polarity, mirroring the flop primitives.
    if (IS_C_INVERTED) begin : g_neg_edge
        // Falling-edge state register with asynchronous restart.
        always_ff @(negedge C or posedge CLR) begin
            if (CLR) begin
                state_q <= S_GSR;
                cnt_q   <= c_gsr_load;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end else begin : g_pos_edge
        // Rising-edge state register with asynchronous restart.
        always_ff @(posedge C or posedge CLR) begin
            if (CLR) begin
                state_q <= S_GSR;
                cnt_q   <= c_gsr_load;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    // Outputs decode straight from the registered state so they are glitch
    // free and follow CLR immediately.
    assign bus.GSR  = (state_q == S_GSR);
    assign bus.GWE  = (state_q != S_GSR);
    assign bus.GTS  = (state_q == S_GSR) || (state_q == S_GWE);
    assign bus.EOS  = (state_q == S_EOS);
    assign bus.DONE = (state_q == S_EOS);

`ifdef STARTUP_STATE_EN
    assign bus.STATE = state_q;
    assign bus.CNT   = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_startup_sequencer.sv
// ============================================================================
// Module      : tb_startup_sequencer
// Description : Self-checking bench for startup_sequencer. A reference model
//               tracks how many enabled edges of progress the sequence has
//               made and derives the expected outputs from the stage lengths.
//               A second instance exercises the falling-edge variant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_startup_sequencer;
    import startup_pkg::*;

    localparam int G  = 8;
    localparam int T  = 4;
    localparam int D  = 2;
    localparam int GI = 1;
    localparam int TI = 4;
    localparam int DI = 2;

    logic C = 1'b0;
    logic CLR;
    logic clr_inv;

    int n_vec = 0;
    int n_err = 0;
    int m_n   = 0;   // progress of the rising-edge instance
    int i_n   = 0;   // progress of the falling-edge instance

    startup_sequencer_if bus ();
    startup_sequencer_if bus_inv ();

    startup_sequencer #(
        .IS_C_INVERTED (1'b0),
        .GSR_CYCLES    (G),
        .GTS_CYCLES    (T),
        .DONE_CYCLES   (D)
    ) dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    startup_sequencer #(
        .IS_C_INVERTED (1'b1),
        .GSR_CYCLES    (GI),
        .GTS_CYCLES    (TI),
        .DONE_CYCLES   (DI)
    ) dut_inv (
        .C   (C),
        .CLR (clr_inv),
        .bus (bus_inv)
    );

    always #5 C = ~C;

    // Progress n = enabled edges consumed since restart. The sequence ends
    // its GTS stage at n = g+t+d-1, where KEEP can hold it; n = g+t+d is EOS.
    function automatic int model_step(input int n, input logic ce, input logic keep,
                                      input logic req, input int g, input int t, input int d);
        int last;
        last = g + t + d - 1;
        if (!ce)        return n;
        if (n < last)   return n + 1;
        if (n == last)  return keep ? n : n + 1;
        return req ? 0 : n;
    endfunction

    // Expected {GSR, GWE, GTS, EOS, DONE} for a given progress.
    function automatic logic [4:0] model_out(input int n, input int g, input int t, input int d);
        logic gsr, gts, eos;
        gsr = (n < g);
        gts = (n < g + t);
        eos = (n >= g + t + d);
        return {gsr, ~gsr, gts, eos, eos};
    endfunction

    function automatic logic [1:0] model_state(input int n, input int g, input int t, input int d);
        if (n < g)         return 2'd0;
        if (n < g + t)     return 2'd1;
        if (n < g + t + d) return 2'd2;
        return 2'd3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag);
        chk(tag, {3'b000, bus.GSR, bus.GWE, bus.GTS, bus.EOS, bus.DONE},
            {3'b000, model_out(m_n, G, T, D)});
`ifdef STARTUP_STATE_EN
        chk({tag, "_state"}, {6'b0, bus.STATE}, {6'b0, model_state(m_n, G, T, D)});
`endif
    endtask

    task automatic check_inv(input string tag);
        chk(tag, {3'b000, bus_inv.GSR, bus_inv.GWE, bus_inv.GTS, bus_inv.EOS, bus_inv.DONE},
            {3'b000, model_out(i_n, GI, TI, DI)});
`ifdef STARTUP_STATE_EN
        chk({tag, "_state"}, {6'b0, bus_inv.STATE}, {6'b0, model_state(i_n, GI, TI, DI)});
`endif
    endtask

    // One rising edge on the main instance, then compare just after it.
    task automatic tick(input string tag);
        @(posedge C);
        m_n = model_step(m_n, bus.CE, bus.KEEP, bus.REQ, G, T, D);
        #1;
        check_main(tag);
    endtask

    // Asynchronous restart between edges; outputs must follow without a clock.
    task automatic clr_pulse(input string tag);
        #1 CLR = 1'b1;
        #1 m_n = 0;
        check_main(tag);
        #1 CLR = 1'b0;
    endtask

    initial begin
        bus.CE      = 1'b0;
        bus.KEEP    = 1'b0;
        bus.REQ     = 1'b0;
        bus_inv.CE  = 1'b1;
        bus_inv.KEEP = 1'b0;
        bus_inv.REQ = 1'b0;
        CLR         = 1'b0;
        clr_inv     = 1'b0;
        #2;
        CLR     = 1'b1;
        clr_inv = 1'b1;
        #1;
        m_n = 0;
        i_n = 0;
        check_main("reset");
        check_inv("reset_inv");

        // Plain run with CE held high: 8 / 12 / 14 edge milestones.
        @(posedge C);
        #1;
        bus.CE = 1'b1;
        CLR    = 1'b0;
        for (int e = 1; e <= 16; e++) tick("ce1_run");

        // Restart request from EOS, full sequence repeats.
        bus.REQ = 1'b1;
        tick("req_in_eos");
        bus.REQ = 1'b0;
        repeat (9) tick("req_rerun");
        // Now in the GWE stage: a request here must be ignored.
        bus.REQ = 1'b1;
        tick("req_in_gwe_ignored");
        bus.REQ = 1'b0;
        repeat (6) tick("req_rerun_tail");

        // CE alternating: every stage takes twice as many clocks.
        clr_pulse("clr_before_toggle");
        for (int i = 0; i < 34; i++) begin
            bus.CE = (i % 2 == 0);
            tick("ce_toggle");
        end
        bus.CE = 1'b1;

        // Asynchronous clear in the middle of the GWE stage.
        clr_pulse("clr_before_gwe");
        repeat (10) tick("to_gwe");
        #2;
        clr_pulse("clr_mid_gwe");
        repeat (16) tick("after_mid_clr");

        // KEEP holds the sequencer in GTS until released.
        clr_pulse("clr_before_keep");
        bus.KEEP = 1'b1;
        repeat (30) tick("keep_hold");
        bus.KEEP = 1'b0;
        tick("keep_drop");
        repeat (2) tick("keep_after");

        // Randomised controls, with occasional asynchronous restarts.
        for (int i = 0; i < 400; i++) begin
            bus.CE   = ($urandom_range(0, 3) != 0);
            bus.KEEP = ($urandom_range(0, 2) == 0);
            bus.REQ  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) clr_pulse("rand_clr");
            tick("rand");
        end

        // Falling-edge instance: only falling edges advance it.
        @(posedge C);
        #1;
        clr_inv = 1'b0;
        i_n     = 0;
        #1;
        check_inv("inv_release");
        for (int i = 0; i < 60; i++) begin
            @(negedge C);
            i_n = model_step(i_n, bus_inv.CE, bus_inv.KEEP, bus_inv.REQ, GI, TI, DI);
            #1;
            check_inv("inv_negedge");
            @(posedge C);
            #1;
            check_inv("inv_posedge_hold");
            if (i >= 10) begin
                bus_inv.CE   = ($urandom_range(0, 3) != 0);
                bus_inv.KEEP = ($urandom_range(0, 3) == 0);
                bus_inv.REQ  = ($urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
